seq_neuron: RTL
===============

# seq_neuron

Parametrised, streaming successor to the fixed 8-input neuron datapath. It accepts weight/input vectors over one or more beats with a valid/ready handshake and accumulates their signed products in a saturating accumulator. It then adds a scaled bias, arithmetic-shifts, saturates and applies an optional ReLU, and holds the sign-magnitude result on a valid/ready output port. It sits between the layer controller's weight/activation fetch and the next layer's input buffer.

## Interface
Parameters:
- DW, 8: data width; sign-magnitude, MSB = sign, DW-1 magnitude bits (weights, inputs, bias, output)
- LANES, 8: products per beat
- ACC_W, 24: two's-complement accumulator width
- SHIFT, 9: arithmetic right shift applied after bias add
- BIAS_SCALE, 127: unsigned multiplier applied to bias magnitude

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  final beat of the current neuron
- w  in  LANES*DW  weights, lane i at [i*DW +: DW]
- inp  in  LANES*DW  inputs, same packing
- bias  in  DW  sign-magnitude bias, sampled on first beat
- relu_en  in  1  activation mode, sampled on first beat
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out  out  DW  sign-magnitude result
- ovf  out  1  accumulator saturated during this neuron; valid with out

## Operation
- Product per lane: magnitude = |w|*|inp| (2*(DW-1) bits), sign = w[MSB]^inp[MSB]. A zero magnitude yields 0, so -0 is treated as 0. Converted to two's complement and summed across lanes (adder tree, width grows 1 bit/level).
- FSM states and transitions:
  - IDLE: in_ready=1. On an accepted beat: acc <= beat_sum, latch bias and relu_en, ovf <= 0. Goes to FIN if in_last, else ACC.
  - ACC: in_ready=1. On an accepted beat: acc <= sat(acc + beat_sum). Goes to FIN on in_last.
  - FIN: in_ready=0. Computes t = acc + sign(bias)*(|bias|*BIAS_SCALE) in ACC_W+1 bits, then r = t >>> SHIFT. Saturates r to ±(2^(DW-1)-1). If relu_en and r<0, r=0. Registers out as sign-magnitude, then goes to OUT.
  - OUT: out_valid=1, in_ready=0. Goes to IDLE on out_ready.
- Accumulator saturation: any sum outside the ACC_W signed range clamps to max or min and sets ovf sticky for the neuron.
- No beat accepted in ACC: acc is held indefinitely.
- Shift is arithmetic: negative values round toward -inf.

## Timing
- Reset values: in_ready=1, out_valid=0, out=0, ovf=0, FSM=IDLE, acc=0. Reset asserted in any state aborts the neuron; nothing is emitted.
- Throughput: one beat per clock in IDLE/ACC.
- Latency: out_valid rises 2 edges after the edge that accepts the in_last beat.
- out and ovf are stable while out_valid && !out_ready. in_ready returns high the cycle after the output handshake.
- A single-beat neuron (in_last on the first beat) is legal.
- in_valid while in_ready=0 is ignored, and the input does not need to hold.

## Structure
- A shared package holds the sign-magnitude to two's-complement conversion and saturation functions, plus the FSM state encoding.
- One sub-module, sm_lane_mult: one signed-magnitude product lane, instantiated LANES times.
- The adder tree, accumulator, FSM and finalise stage live in the top module.

## Test plan
All scenarios use default parameters.
- One beat, all lanes w=inp=0x7F, bias=0, relu_en=0 -> sum 129032, >>9 = 252, saturated -> out=0x7F, ovf=0, out_valid 2 edges after accept.
- One beat, inputs all 0x00 (including -0 as 0x80), bias=0x64 -> 12700>>9 -> out=0x18.
- One beat, zero inputs, bias=0xE4 (-100): relu_en=0 -> out=0x99 (-25); relu_en=1 -> out=0x00.
- Four beats, w=0x40, inp=0x08 on all lanes, with in_valid gaps; hold out_ready low 5 cycles -> out=0x20 held stable, in_ready=0 throughout, then IDLE.
- 70 beats of w=inp=0x7F -> acc clamps at 8388607, ovf=1, out=0x7F. The next neuron starts with ovf cleared.
- Assert rst mid-ACC after 2 beats -> out_valid=0, in_ready=1 immediately. A new single-beat neuron then gives a result independent of the aborted beats.

Source files
------------

// File: rtl/seq_neuron_pkg.sv
// Shared types and arithmetic helpers for the streaming neuron datapath.
package seq_neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_FIN,
    ST_OUT
  } state_t;

  // Wide working width for intermediate arithmetic; callers size-cast results down.
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Sign-magnitude to two's complement; a zero magnitude is +0 whatever the sign bit.
  function automatic calc_t sm_to_tc(input logic sign, input logic [CALC_W-1:0] mag);
    calc_t v;
    v = calc_t'(mag);
    return (sign && (mag != '0)) ? -v : v;
  endfunction

  // Clamp v to a w-bit signed range; sym selects +/-(2^(w-1)-1) instead of the full range.
  function automatic calc_t sat(input calc_t v, input int w, input logic sym);
    calc_t hi;
    calc_t lo;
    calc_t res;
    hi  = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    lo  = sym ? -hi : -hi - calc_t'(1);
    res = v;
    if (v > hi) begin
      res = hi;
    end else if (v < lo) begin
      res = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_neuron_lane.sv
// One sign-magnitude product lane: |w|*|inp| with XOR'd sign, returned in two's complement.
module sm_lane_mult
  import seq_neuron_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0]         w,
  input  logic [DW-1:0]         inp,
  output logic signed [2*(DW-1):0] prod
);

  localparam int MW = 2 * (DW - 1);

  logic [MW-1:0] mag;

  // Unsigned magnitude multiply, then sign application (zero magnitude stays +0).
  always_comb begin
    mag  = MW'(w[DW-2:0]) * MW'(inp[DW-2:0]);
    prod = (MW + 1)'(sm_to_tc(w[DW-1] ^ inp[DW-1], CALC_W'(mag)));
  end

endmodule

// File: rtl/seq_neuron.sv
// Streaming multi-beat neuron: lane products, saturating accumulate, bias/shift/ReLU finalise.
module seq_neuron
  import seq_neuron_pkg::*;
#(
  parameter int DW         = 8,
  parameter int LANES      = 8,
  parameter int ACC_W      = 24,
  parameter int SHIFT      = 9,
  parameter int BIAS_SCALE = 127
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [LANES*DW-1:0] w,
  input  logic [LANES*DW-1:0] inp,
  input  logic [DW-1:0]       bias,
  input  logic                relu_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out,
  output logic                ovf
);

  localparam int PW = 2 * (DW - 1) + 1;
  localparam int SW = PW + $clog2(LANES);

  logic signed [PW-1:0]  prod [LANES];
  logic signed [SW-1:0]  beat_sum;
  state_t                state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   t_q;
  logic [DW-1:0]         bias_q;
  logic                  relu_q;
  logic                  fin_phase;
  calc_t                 sum_raw;
  calc_t                 sum_sat;
  logic                  sum_clip;
  calc_t                 bias_term;
  calc_t                 r_sh;
  calc_t                 r_act;
  logic [DW-2:0]         r_mag;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sm_lane_mult #(.DW(DW)) u_lane (
      .w    (w[i*DW +: DW]),
      .inp  (inp[i*DW +: DW]),
      .prod (prod[i])
    );
  end

  // Cross-lane sum; synthesis balances this into an adder tree sized for LANES products.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a value on every path, otherwise a latch is inferred.
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum += SW'(prod[i]);
    end
  end

  // Next accumulator value with saturation, and finalise arithmetic from the registered stages.
  always_comb begin
    sum_raw   = (state == ST_IDLE) ? calc_t'(beat_sum) : calc_t'(acc) + calc_t'(beat_sum);
    sum_sat   = sat(sum_raw, ACC_W, 1'b0);
    sum_clip  = (sum_sat != sum_raw);
    bias_term = sm_to_tc(bias_q[DW-1], CALC_W'(bias_q[DW-2:0]) * CALC_W'(BIAS_SCALE));
    r_sh      = sat(calc_t'(t_q) >>> SHIFT, DW, 1'b1);
    r_act     = (relu_q && (r_sh < 0)) ? '0 : r_sh;
    r_mag     = (DW - 1)'((r_act < 0) ? -r_act : r_act);
  end

  // Control FSM with registered handshake outputs; the bias add is registered before shift/saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      t_q       <= '0;
      bias_q    <= '0;
      relu_q    <= 1'b0;
      fin_phase <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      unique case (state)
        ST_IDLE, ST_ACC: begin
          if (in_valid && in_ready) begin
            acc <= ACC_W'(sum_sat);
            ovf <= ((state == ST_IDLE) ? 1'b0 : ovf) | sum_clip;
            if (state == ST_IDLE) begin
              bias_q <= bias;
              relu_q <= relu_en;
            end
            if (in_last) begin
              state    <= ST_FIN;
              in_ready <= 1'b0;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_FIN: begin
          if (!fin_phase) begin
            t_q       <= (ACC_W + 1)'(calc_t'(acc) + bias_term);
            fin_phase <= 1'b1;
          end else begin
            out       <= {r_act < 0, r_mag};
            fin_phase <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
